winograd_conv_10x12: RTL and testbench

WINOGRAD_CONV_10X12 -- requirements
Module: winograd_conv_10x12

---
 rtl/winograd_pkg.sv | 26 ++
 rtl/winograd_tile_f2x3.sv | 58 +++++
 rtl/winograd_conv_10x12.sv | 154 +++++++++++++++
 tb/tb_winograd_conv_10x12.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/winograd_pkg.sv
// Shared dimensions, FSM state type and sign-extension helper for the
// Winograd F(2x2,3x3) 10x12 convolution block.
package winograd_pkg;

  localparam int DATA_W  = 32;
  localparam int INT_W   = 34;
  localparam int IMG_H   = 10;
  localparam int IMG_W   = 12;
  localparam int K       = 3;
  localparam int OUT_H   = 8;
  localparam int OUT_W   = 10;
  localparam int TILES_R = 4;
  localparam int TILES_C = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KXFORM = 2'd1,
    TILE   = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic logic [INT_W-1:0] sext34(input logic [DATA_W-1:0] x);
    return {{(INT_W-DATA_W){x[DATA_W-1]}}, x};
  endfunction

endpackage

// File: rtl/winograd_tile_f2x3.sv
// Combinational F(2x2,3x3) tile: B^T d B, elementwise product with the
// pre-transformed (2G) kernel, A^T m A, all mod 2^34, then divide by 4.
module winograd_tile_f2x3
  import winograd_pkg::*;
(
  input  logic [DATA_W-1:0] d_i [0:3][0:3],
  input  logic [INT_W-1:0]  u_i [0:3][0:3],
  output logic [DATA_W-1:0] y_o [0:1][0:1]
);

  logic [INT_W-1:0] d_s  [0:3][0:3];
  logic [INT_W-1:0] bt_s [0:3][0:3];
  logic [INT_W-1:0] v_s  [0:3][0:3];
  logic [INT_W-1:0] m_s  [0:3][0:3];
  logic [INT_W-1:0] w_s  [0:1][0:3];
  logic [INT_W-1:0] s_s  [0:1][0:1];

  // Full tile datapath; every intermediate wraps at 34 bits.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        d_s[r][c] = sext34(d_i[r][c]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      bt_s[0][c] = d_s[0][c] - d_s[2][c];
      bt_s[1][c] = d_s[1][c] + d_s[2][c];
      bt_s[2][c] = d_s[2][c] - d_s[1][c];
      bt_s[3][c] = d_s[1][c] - d_s[3][c];
    end
    for (int r = 0; r < 4; r++) begin
      v_s[r][0] = bt_s[r][0] - bt_s[r][2];
      v_s[r][1] = bt_s[r][1] + bt_s[r][2];
      v_s[r][2] = bt_s[r][2] - bt_s[r][1];
      v_s[r][3] = bt_s[r][1] - bt_s[r][3];
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        m_s[r][c] = u_i[r][c] * v_s[r][c];
      end
    end
    for (int c = 0; c < 4; c++) begin
      w_s[0][c] = m_s[0][c] + m_s[1][c] + m_s[2][c];
      w_s[1][c] = m_s[1][c] - m_s[2][c] - m_s[3][c];
    end
    for (int r = 0; r < 2; r++) begin
      s_s[r][0] = w_s[r][0] + w_s[r][1] + w_s[r][2];
      s_s[r][1] = w_s[r][1] - w_s[r][2] - w_s[r][3];
    end
    // The 2G kernel scales the result by 4; bits [33:2] are the exact low 32 bits.
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        y_o[r][c] = DATA_W'(s_s[r][c] >> 2);
      end
    end
  end

endmodule

// File: rtl/winograd_conv_10x12.sv
// 10x12 image, 3x3 kernel valid-mode correlation using Winograd F(2x2,3x3):
// capture, one kernel-transform cycle, then one 2x2 output tile per cycle.
module winograd_conv_10x12
  import winograd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] image_in   [0:IMG_H-1][0:IMG_W-1],
  input  logic [DATA_W-1:0] kernel_in  [0:K-1][0:K-1],
  output logic [DATA_W-1:0] result_out [0:OUT_H-1][0:OUT_W-1],
  output logic              done
);

  state_t            state_q, state_d;
  logic [1:0]        tr_q, tr_d;
  logic [2:0]        tc_q, tc_d;
  logic              done_q, done_d;
  logic              capture_s, kx_en_s, tile_en_s, last_tile_s;

  logic [DATA_W-1:0] img_q    [0:IMG_H-1][0:IMG_W-1];
  logic [DATA_W-1:0] ker_q    [0:K-1][0:K-1];
  logic [INT_W-1:0]  u_q      [0:3][0:3];
  logic [INT_W-1:0]  u_d      [0:3][0:3];
  logic [INT_W-1:0]  g_s      [0:K-1][0:K-1];
  logic [INT_W-1:0]  t_s      [0:3][0:K-1];
  logic [DATA_W-1:0] tile_s   [0:3][0:3];
  logic [DATA_W-1:0] y_s      [0:1][0:1];
  logic [DATA_W-1:0] result_q [0:OUT_H-1][0:OUT_W-1];

  assign last_tile_s = (tr_q == 2'(TILES_R - 1)) && (tc_q == 3'(TILES_C - 1));

  // State and tile-index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tr_q    <= 2'd0;
      tc_q    <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tr_q    <= tr_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; DONE always returns to IDLE so start there is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = KXFORM; else state_d = IDLE;
      KXFORM:  state_d = TILE;
      TILE:    if (last_tile_s) state_d = DONE; else state_d = TILE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-state enables, raster tile counter and the registered done pulse.
  always_comb begin
    capture_s = (state_q == IDLE) && start;
    kx_en_s   = (state_q == KXFORM);
    tile_en_s = (state_q == TILE);
    done_d    = (state_q == TILE) && last_tile_s;
    tr_d      = tr_q;
    tc_d      = tc_q;
    if (state_q == KXFORM) begin
      tr_d = 2'd0;
      tc_d = 3'd0;
    end else if ((state_q == TILE) && !last_tile_s) begin
      if (tc_q == 3'(TILES_C - 1)) begin
        tc_d = 3'd0;
        tr_d = tr_q + 2'd1;
      end else begin
        tc_d = tc_q + 3'd1;
        tr_d = tr_q;
      end
    end else begin
      tr_d = tr_q;
      tc_d = tc_q;
    end
  end

  // Kernel transform (2G) g (2G)^T, integer coefficients only.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        g_s[r][c] = sext34(ker_q[r][c]);
      end
    end
    for (int c = 0; c < K; c++) begin
      t_s[0][c] = g_s[0][c] + g_s[0][c];
      t_s[1][c] = g_s[0][c] + g_s[1][c] + g_s[2][c];
      t_s[2][c] = g_s[0][c] - g_s[1][c] + g_s[2][c];
      t_s[3][c] = g_s[2][c] + g_s[2][c];
    end
    for (int i = 0; i < 4; i++) begin
      u_d[i][0] = t_s[i][0] + t_s[i][0];
      u_d[i][1] = t_s[i][0] + t_s[i][1] + t_s[i][2];
      u_d[i][2] = t_s[i][0] - t_s[i][1] + t_s[i][2];
      u_d[i][3] = t_s[i][2] + t_s[i][2];
    end
  end

  // 4x4 window of the captured image for the current tile.
  always_comb begin
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        tile_s[a][b] = img_q[{1'b0, tr_q, 1'b0} + 4'(a)][{tc_q, 1'b0} + 4'(b)];
      end
    end
  end

  winograd_tile_f2x3 u_tile (
    .d_i (tile_s),
    .u_i (u_q),
    .y_o (y_s)
  );

  // Input capture on the accepted start; nothing is sampled afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IMG_H; i++)
        for (int j = 0; j < IMG_W; j++) img_q[i][j] <= '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) ker_q[r][c] <= '0;
    end else if (capture_s) begin
      img_q <= image_in;
      ker_q <= kernel_in;
    end
  end

  // Transformed kernel and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) u_q[i][j] <= '0;
      for (int i = 0; i < OUT_H; i++)
        for (int j = 0; j < OUT_W; j++) result_q[i][j] <= '0;
    end else begin
      if (kx_en_s) u_q <= u_d;
      if (tile_en_s) begin
        for (int a = 0; a < 2; a++)
          for (int b = 0; b < 2; b++)
            result_q[{tr_q, 1'b0} + 3'(a)][{tc_q, 1'b0} + 4'(b)] <= y_s[a][b];
      end
    end
  end

  assign result_out = result_q;
  assign done       = done_q;

endmodule

// File: tb/tb_winograd_conv_10x12.sv
// Directed, table-driven bench for winograd_conv_10x12 with closed-form
// expected values plus hand-written timing/reset sequences.
module tb_winograd_conv_10x12;
  import winograd_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [DATA_W-1:0] image_in   [0:IMG_H-1][0:IMG_W-1];
  logic [DATA_W-1:0] kernel_in  [0:K-1][0:K-1];
  logic [DATA_W-1:0] result_out [0:OUT_H-1][0:OUT_W-1];
  logic              done;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          mode;
    int          ri;
    int          rj;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [0:10];

  always #5 clk = ~clk;

  winograd_conv_10x12 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .image_in   (image_in),
    .kernel_in  (kernel_in),
    .result_out (result_out),
    .done       (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Closed-form expectations: 0 ramp, 1 identity, 2 signed, 3 wrap / cleared.
  function automatic logic [31:0] expect_val(input int mode, input int i, input int j);
    case (mode)
      0:       return 32'(852 + 540 * i + 45 * j);
      1:       return 32'(12 * i + j + 14);
      2:       return 32'hFFFF_FFF7;
      default: return 32'h0000_0000;
    endcase
  endfunction

  task automatic load(input int mode);
    for (int i = 0; i < IMG_H; i++)
      for (int j = 0; j < IMG_W; j++)
        case (mode)
          0, 1:    image_in[i][j] = 32'(12 * i + j + 1);
          2:       image_in[i][j] = 32'd1;
          3:       image_in[i][j] = 32'h4000_0000;
          default: image_in[i][j] = $urandom();
        endcase
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        case (mode)
          0:       kernel_in[r][c] = 32'(3 * r + c + 1);
          1:       kernel_in[r][c] = (r == 1 && c == 1) ? 32'd1 : 32'd0;
          2:       kernel_in[r][c] = 32'hFFFF_FFFF;
          3:       kernel_in[r][c] = 32'd4;
          default: kernel_in[r][c] = $urandom();
        endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int mode, input string tag);
    for (int i = 0; i < OUT_H; i++)
      for (int j = 0; j < OUT_W; j++)
        check($sformatf("%s[%0d][%0d]", tag, i, j), result_out[i][j], expect_val(mode, i, j));
  endtask

  // Pulse start, optionally disturb inputs and re-pulse start mid-run; check
  // latency (edges counted including the sampling edge) and pulse count.
  task automatic run_conv(input bit disturb, input string tag);
    int lat;
    int cnt;
    lat = -1;
    cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (disturb) load(99);
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (disturb && k == 8) start = 1'b1;
      if (disturb && k == 9) start = 1'b0;
      if (done) begin
        cnt++;
        if (lat < 0) lat = k + 1;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd22);
    check({tag, "_done_pulses"}, 32'(cnt), 32'd1);
  endtask

  initial begin
    int cur;
    int dq [$];

    tbl[0]  = '{0, 0, 0, 32'd852};
    tbl[1]  = '{0, 0, 1, 32'd897};
    tbl[2]  = '{0, 7, 9, 32'd5037};
    tbl[3]  = '{0, 3, 4, 32'd2652};
    tbl[4]  = '{1, 0, 0, 32'd14};
    tbl[5]  = '{1, 7, 9, 32'd107};
    tbl[6]  = '{1, 4, 6, 32'd68};
    tbl[7]  = '{2, 0, 0, 32'hFFFF_FFF7};
    tbl[8]  = '{2, 7, 9, 32'hFFFF_FFF7};
    tbl[9]  = '{3, 0, 0, 32'h0000_0000};
    tbl[10] = '{3, 5, 5, 32'h0000_0000};

    rst_n = 1'b0;
    start = 1'b0;
    load(0);
    tick();
    tick();
    check_all(3, "reset");
    check("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    cur = -1;
    for (int v = 0; v <= 10; v++) begin
      if (tbl[v].mode != cur) begin
        cur = tbl[v].mode;
        load(cur);
        run_conv(1'b0, $sformatf("mode%0d", cur));
        check_all(cur, $sformatf("full_mode%0d", cur));
      end
      check($sformatf("vec%0d[%0d][%0d]", v, tbl[v].ri, tbl[v].rj),
            result_out[tbl[v].ri][tbl[v].rj], tbl[v].exp);
    end

    // Input change after capture plus a mid-run start must not disturb the run.
    load(0);
    run_conv(1'b1, "disturb");
    check_all(0, "disturb");

    // Held start: one run per IDLE visit, DONE ignores start -> 23-cycle period.
    load(0);
    start = 1'b1;
    for (int e = 0; e < 80; e++) begin
      tick();
      if (e == 49) start = 1'b0;
      if (done) dq.push_back(e);
    end
    check("held_runs", 32'(dq.size()), 32'd3);
    for (int n = 0; n < 3; n++) begin
      if (n < dq.size()) check($sformatf("held_done_edge%0d", n), 32'(dq[n]), 32'(21 + 23 * n));
      else check($sformatf("held_done_edge%0d", n), 32'hFFFF_FFFF, 32'(21 + 23 * n));
    end

    // Reset during tile 10 aborts the run and clears all results.
    load(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    rst_n = 1'b0;
    #1;
    check_all(3, "midreset");
    check("midreset_done", 32'(done), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("inreset_done%0d", k), 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    cur = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done) cur++;
    end
    check("postreset_no_done", 32'(cur), 32'd0);
    check_all(3, "postreset_idle");
    run_conv(1'b0, "after_reset");
    check_all(0, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
